dlfloat_dot_seq: RTL and testbench
==================================

Name: dlfloat_dot_seq

Overview:
- Initiator-side sequencer for the dlfloat_mac accumulator.
- Accepts a start command with a vector length, then streams operand pairs (a_i, b_i) into the MAC through a valid/ready handshake.
- Clears the MAC accumulator before each vector, waits out the MAC pipeline latency, captures the dot product and presents it on a valid/ready result port.
- Sits between the operand buffer/DMA and a dlfloat_mac instance. All values use the DLFloat16 format: 1 sign, 6 exponent (bias 31), 9 mantissa.

Parameters:
- LEN_W, 8: width of the vector-length field; max vector length is 2^LEN_W-1.
- MAC_LAT, 2: edges from an operand pair at the MAC inputs to its contribution appearing on the MAC c_out (1 multiplier register + 1 accumulator register).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle command pulse; accepted only in IDLE
- len  in  LEN_W  number of operand pairs; sampled with an accepted start
- busy  out  1  high in every state except IDLE
- s_valid  in  1  operand pair valid
- s_ready  out  1  sequencer can accept an operand pair
- s_a  in  16  operand A (DLFloat16)
- s_b  in  16  operand B (DLFloat16)
- mac_rst_n  out  1  drives dlfloat_mac rst_n
- mac_a  out  16  drives dlfloat_mac a
- mac_b  out  16  drives dlfloat_mac b
- mac_c  in  16  dlfloat_mac c_out
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_data  out  16  dot-product result (DLFloat16)

Behaviour:
- Reset: clk rising edge with rst_n=0. State goes to IDLE; element counter, drain counter and m_data go to 0; m_valid goes to 0. Resetting mid-operation abandons the vector with no result.
- mac_rst_n = rst_n AND (state != CLEAR). It is a decode of registered state only.
- mac_a/mac_b = s_a/s_b when state==FEED and s_valid=1; otherwise 16'h0000. Zero operands add +0 and leave the accumulator unchanged.
- s_ready = (state==FEED). A transfer occurs when s_valid and s_ready are both high at a clock edge.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE: on start=1, latch len into the element counter, go to CLEAR.
  - CLEAR: lasts exactly 1 cycle (mac_rst_n=0). Go to FEED if len!=0, else to DRAIN.
  - FEED: each transfer decrements the counter. The transfer that takes the counter to 0 moves to DRAIN. Bubbles (s_valid=0) hold the state indefinitely with no timeout.
  - DRAIN: lasts exactly MAC_LAT cycles. At the edge leaving DRAIN, capture mac_c into m_data, set m_valid=1, go to DONE.
  - DONE: hold m_data/m_valid stable until m_valid and m_ready are both high at an edge. At that edge clear m_valid and go to IDLE.
- len=0: the sequence is CLEAR then DRAIN, and the result is the cleared accumulator, 16'h0000.
- Latency: start edge to first s_ready is 2 cycles; last transfer edge to m_valid high is MAC_LAT cycles. Minimum command turnaround is len+MAC_LAT+3 cycles with m_ready held high.
- start outside IDLE is ignored: no queuing, and len is not resampled.
- start and the DONE handshake in the same cycle: start is ignored, because the state is not yet IDLE.
- s_valid outside FEED is ignored; the MAC sees zeros.
- Arithmetic: none performed locally. Rounding, overflow and NaN behaviour are those of dlfloat_mac.

Decomposition:
- Shared package holds:
  - DLFloat constants: DLF_ZERO=16'h0000, DLF_ONE=16'h3E00, EXP_W=6, MAN_W=9, BIAS=31.
  - FSM state enum.
  - Default MAC_LAT=2, so the MAC and the sequencer stay consistent.
- No sub-module. The wrapper dlfloat_dot_unit (future) instantiates dlfloat_dot_seq plus dlfloat_mac.

Test Plan:
- len=3, pairs (3E00,3E00)x3, s_valid always 1, m_ready=1 -> m_data=16'h4100 (3.0), m_valid high exactly 1 cycle, 3+MAC_LAT+2 cycles after start.
- len=1, (4000,4000) -> m_data=16'h4200 (4.0). A second vector len=1 (3E00,3E00) immediately after -> 16'h3E00, proving CLEAR wiped the previous accumulation.
- len=2 with s_valid low for 5 cycles between the pairs (3E00,4000),(3E00,3E00) -> mac_a/mac_b=0 during bubbles, result 16'h4100.
- len=0 -> m_data=16'h0000, m_valid 1 cycle after the CLEAR cycle plus MAC_LAT, s_ready never high.
- m_ready held low 10 cycles in DONE, with start pulsed during that window -> m_data/m_valid stable, start ignored, busy=1. Return to IDLE only after the handshake.
- rst_n low for 1 cycle mid-FEED (after 1 of 4 pairs) -> next cycle IDLE, busy=0, m_valid=0, s_ready=0. The following len=1 (3E00,3E00) vector yields 16'h3E00.

Source files
------------

// File: rtl/dlfloat_dot_seq_pkg.sv
// rtl/dlfloat_dot_seq_pkg.sv - DLFloat16 constants and sequencer state encoding
package dlfloat_dot_seq_pkg;

  localparam int DLF_W = 16;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

  // Shared with dlfloat_mac so both sides agree on the pipeline depth.
  localparam int MAC_LAT_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/dlfloat_dot_seq.sv
// rtl/dlfloat_dot_seq.sv - dot-product sequencer driving a dlfloat_mac accumulator
module dlfloat_dot_seq
  import dlfloat_dot_seq_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DLF_W-1:0] s_a,
  input  logic [DLF_W-1:0] s_b,
  output logic             mac_rst_n,
  output logic [DLF_W-1:0] mac_a,
  output logic [DLF_W-1:0] mac_b,
  input  logic [DLF_W-1:0] mac_c,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DLF_W-1:0] m_data
);

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

  seq_state_e         state;
  seq_state_e         state_nxt;
  logic [LEN_W-1:0]   elem_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               xfer;
  logic               res_hs;
  logic               drain_end;

  assign s_ready   = (state == ST_FEED);
  assign busy      = (state != ST_IDLE);
  assign xfer      = s_valid & s_ready;
  assign res_hs    = m_valid & m_ready;
  assign drain_end = (state == ST_DRAIN) && (drain_cnt == '0);

  // Registered-state decode only, so the MAC reset is glitch-free.
  assign mac_rst_n = rst_n & (state != ST_CLEAR);
  assign mac_a     = (xfer) ? s_a : DLF_ZERO;
  assign mac_b     = (xfer) ? s_b : DLF_ZERO;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nxt = (elem_cnt != '0) ? ST_FEED : ST_DRAIN;
      end
      ST_FEED: begin
        if (xfer && (elem_cnt == LEN_W'(1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (res_hs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        elem_cnt <= len;
      end else if (xfer) begin
        elem_cnt <= elem_cnt - LEN_W'(1);
      end

      // Load on entry so DRAIN spans exactly MAC_LAT cycles.
      if ((state_nxt == ST_DRAIN) && (state != ST_DRAIN)) begin
        drain_cnt <= DRAIN_LAST;
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DRAIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data  <= DLF_ZERO;
      m_valid <= 1'b0;
    end else if (drain_end) begin
      m_data  <= mac_c;
      m_valid <= 1'b1;
    end else if (res_hs) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// tb/tb_dlfloat_dot_seq.sv - scoreboard bench for dlfloat_dot_seq with a behavioural MAC
module tb_dlfloat_dot_seq;
  import dlfloat_dot_seq_pkg::*;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_a;
  logic [15:0]      s_b;
  logic             mac_rst_n;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic [15:0]      mac_c;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      m_data;

  dlfloat_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .mac_rst_n(mac_rst_n), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic real dec(input logic [15:0] v);
    real m;
    int  e;
    if (v[14:9] == 6'd0) return 0.0;
    m = 1.0 + real'(int'(v[8:0])) / 512.0;
    e = int'(v[14:9]) - 31;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input real x);
    logic s;
    real  ax;
    int   e;
    int   man;
    if (x == 0.0) return 16'h0000;
    s  = (x < 0.0);
    ax = s ? -x : x;
    e  = 0;
    while (ax >= 2.0) begin ax = ax / 2.0; e++; end
    while (ax < 1.0) begin ax = ax * 2.0; e--; end
    man = int'((ax - 1.0) * 512.0);
    return {s, 6'(e + 31), 9'(man)};
  endfunction

  // Behavioural stand-in for dlfloat_mac: product register then accumulator register.
  real prod_r = 0.0;
  real acc_r  = 0.0;
  always @(posedge clk) begin
    if (!mac_rst_n) begin
      prod_r <= 0.0;
      acc_r  <= 0.0;
    end else begin
      prod_r <= dec(mac_a) * dec(mac_b);
      acc_r  <= acc_r + prod_r;
    end
  end
  assign mac_c = enc(acc_r);

  logic [15:0] exp_q[$];
  int  start_cyc  = 0;
  int  rise_cyc   = 0;
  int  valid_cnt  = 0;
  int  sready_cnt = 0;
  bit  mv_prev    = 1'b0;
  bit  rand_ready = 1'b0;

  always @(negedge clk) begin
    if (m_valid && !mv_prev) rise_cyc = cyc;
    if (m_valid) valid_cnt++;
    if (s_ready) sready_cnt++;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %h, expected no result", m_data);
      end else begin
        check("result", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
      end
    end
    mv_prev = m_valid;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_ready = 1'($urandom_range(1, 0));
    end
  end

  task automatic issue(input int n);
    start     = 1'b1;
    len       = LEN_W'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gap < 0 means a random bubble of 0..3 cycles before every pair.
  task automatic feed(input logic [15:0] a[$], input logic [15:0] b[$], input int gap);
    bit rdy;
    int budget;
    int k;
    for (int i = 0; i < a.size(); i++) begin
      k = (gap < 0) ? int'($urandom_range(3, 0)) : ((i == 0) ? 0 : gap);
      repeat (k) begin
        s_valid = 1'b0;
        @(negedge clk);
        check("bubble_mac_zero", {mac_a, mac_b}, 32'h0);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_a     = a[i];
      s_b     = b[i];
      budget  = 0;
      do begin
        @(negedge clk);
        rdy = s_ready;
        if (rdy) check("feed_mac_pass", {mac_a, mac_b}, {a[i], b[i]});
        else     check("notready_mac_zero", {mac_a, mac_b}, 32'h0);
        @(posedge clk); #1;
        budget++;
      end while (!rdy && budget < 50);
      if (!rdy) begin
        n_cmp++;
        n_err++;
        $display("FAIL feed_timeout: got s_ready=0 after %0d cycles, expected 1", budget);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy=1, expected 0");
    end
  endtask

  task automatic run_vec(input logic [15:0] a[$], input logic [15:0] b[$], input int gap,
                         input bit check_lat);
    real dot = 0.0;
    for (int i = 0; i < a.size(); i++) dot += dec(a[i]) * dec(b[i]);
    exp_q.push_back(enc(dot));
    issue(a.size());
    feed(a, b, gap);
    wait_idle();
    if (check_lat) check("latency", 32'(rise_cyc - start_cyc), 32'(a.size() + MAC_LAT + 2));
  endtask

  logic [15:0] op_tab[6] = '{16'h3E00, 16'h4000, 16'hBE00, 16'h3C00, 16'h3F00, 16'h0000};

  initial begin
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] held;
    int          b;
    int          n;
    int          gap;

    rst_n = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0;
    s_a = 16'h0; s_b = 16'h0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mac_rst_n_in_reset", {31'h0, mac_rst_n}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_s_ready", {31'h0, s_ready}, 32'h0);
    check("reset_m_valid", {31'h0, m_valid}, 32'h0);
    check("reset_m_data", {16'h0, m_data}, 32'h0);
    check("reset_mac_rst_n", {31'h0, mac_rst_n}, 32'h1);
    @(posedge clk); #1;

    // 1+1+1 -> 3.0, m_valid for exactly one cycle
    valid_cnt = 0;
    qa = '{16'h3E00, 16'h3E00, 16'h3E00}; qb = '{16'h3E00, 16'h3E00, 16'h3E00};
    run_vec(qa, qb, 0, 1'b1);
    check("const_3p0", {16'h0, enc(3.0)}, 32'h4100);
    check("valid_one_cycle", 32'(valid_cnt), 32'd1);

    // back-to-back: second result must not include the first
    qa = '{16'h4000}; qb = '{16'h4000};
    run_vec(qa, qb, 0, 1'b1);
    qa = '{16'h3E00}; qb = '{16'h3E00};
    run_vec(qa, qb, 0, 1'b1);

    // bubbles between pairs
    qa = '{16'h3E00, 16'h3E00}; qb = '{16'h4000, 16'h3E00};
    run_vec(qa, qb, 5, 1'b0);

    // empty vector
    sready_cnt = 0;
    qa.delete(); qb.delete();
    run_vec(qa, qb, 0, 1'b1);
    check("len0_no_s_ready", 32'(sready_cnt), 32'd0);

    // result held while m_ready is low; start ignored in DONE
    m_ready = 1'b0;
    qa = '{16'h3F00}; qb = '{16'h4000};
    exp_q.push_back(enc(3.0));
    issue(1);
    feed(qa, qb, 0);
    b = 0;
    while (!m_valid && b < 50) begin @(posedge clk); #1; b++; end
    check("done_reached", {31'h0, m_valid}, 32'h1);
    held = enc(3.0);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      len   = LEN_W'(5);
      @(negedge clk);
      check("hold_m_valid", {31'h0, m_valid}, 32'h1);
      check("hold_m_data", {16'h0, m_data}, {16'h0, held});
      check("hold_busy", {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
    end
    start = 1'b1; len = LEN_W'(7); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("after_hs_busy", {31'h0, busy}, 32'h0);
    check("after_hs_m_valid", {31'h0, m_valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_in_done_ignored", {31'h0, busy}, 32'h0);
    check("start_in_done_s_ready", {31'h0, s_ready}, 32'h0);
    @(posedge clk); #1;

    // reset mid-FEED abandons the vector
    issue(4);
    qa = '{16'h4000}; qb = '{16'h4000};
    feed(qa, qb, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_m_valid", {31'h0, m_valid}, 32'h0);
    check("midreset_s_ready", {31'h0, s_ready}, 32'h0);
    @(posedge clk); #1;
    qa = '{16'h3E00}; qb = '{16'h3E00};
    run_vec(qa, qb, 0, 1'b1);

    // randomized vectors with random bubbles and back-pressure
    rand_ready = 1'b1;
    for (int v = 0; v < 30; v++) begin
      n = int'($urandom_range(6, 0));
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(op_tab[$urandom_range(5, 0)]);
        qb.push_back(op_tab[$urandom_range(5, 0)]);
      end
      gap = ($urandom_range(1, 0) == 0) ? 0 : -1;
      run_vec(qa, qb, gap, gap == 0);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
